// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared register map, mode encoding and divider helper for multi_channel_timer
package timer_pkg;

    localparam logic [7:0] OFF_EN      = 8'd0;
    localparam logic [7:0] OFF_MODE    = 8'd1;
    localparam logic [7:0] OFF_RESTART = 8'd2;
    localparam logic [7:0] OFF_STATUS  = 8'd3;
    localparam logic [7:0] OFF_IMASK   = 8'd4;
    localparam logic [7:0] OFF_OVERRUN = 8'd5;
    localparam int         CH_BASE     = 8;
    localparam int         CH_STRIDE   = 4;

    localparam logic [1:0] SUB_PERIOD_LO = 2'd0;
    localparam logic [1:0] SUB_PERIOD_HI = 2'd1;
    localparam logic [1:0] SUB_COUNT_LO  = 2'd2;
    localparam logic [1:0] SUB_COUNT_HI  = 2'd3;

    typedef enum logic {
        PERIODIC = 1'b0,
        ONESHOT  = 1'b1
    } mode_e;

    function automatic int calc_div(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: period register, tick counter, event and one-shot disarm
module timer_channel
    import timer_pkg::*;
#(
    parameter int          CNT_W        = 16,
    parameter logic [15:0] RESET_PERIOD = 16'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             en,
    input  mode_e            mode,
    input  logic             restart,
    input  logic             wr_lo,
    input  logic             wr_hi,
    input  logic [7:0]       wdata,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] period,
    output logic             fire,
    output logic             disarm
);

    logic [15:0] period_full;
    logic        active;
    logic        at_end;

    assign period = period_full[CNT_W-1:0];
    assign active = en && (period != '0) && tick;
    assign at_end = (count == period - CNT_W'(1));
    assign fire   = active && at_end && !restart;
    assign disarm = fire && (mode == ONESHOT);

    // High period byte only exists for 16-bit channels; it stays 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_full <= RESET_PERIOD;
        end else begin
            if (wr_lo)
                period_full[7:0] <= wdata;
            if (wr_hi && (CNT_W == 16))
                period_full[15:8] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (restart)
            count <= '0;
        else if (active)
            count <= at_end ? '0 : count + CNT_W'(1);
    end

endmodule

// File: rtl/multi_channel_timer.sv
// rtl/multi_channel_timer.sv - NUM_CH-channel bus timer; optional OVERRUN flags under TIMER_OVERRUN_EN
module multi_channel_timer
    import timer_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR      = 8'hE0,
    parameter int         NUM_CH         = 2,
    parameter int         CNT_W          = 16,
    parameter int         CLK_HZ         = 100000000,
    parameter int         TICK_HZ        = 1000,
    parameter int         DEFAULT_PERIOD = 100
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    localparam int DIV = calc_div(CLK_HZ, TICK_HZ);
    localparam int PW  = $clog2(DIV);
    localparam int WIN = CH_BASE + CH_STRIDE * NUM_CH;

    logic [PW-1:0]     presc;
    logic              tick;
    logic [7:0]        offset;
    logic [7:0]        ch_off;
    logic [5:0]        ch_idx;
    logic [1:0]        sub;
    logic              hit, wr, rd, is_glob;
    logic [7:0]        wdata;
    logic [NUM_CH-1:0] wbits;

    logic [NUM_CH-1:0] en_q, mode_q, status_q, imask_q;
    logic [NUM_CH-1:0] en_next, status_next;
    logic [NUM_CH-1:0] restart, fire, disarm, ovr_rd;
    logic [15:0]       count_ext  [NUM_CH];
    logic [15:0]       period_ext [NUM_CH];
    logic [7:0]        shadow     [NUM_CH];
    logic [7:0]        rd_mux, rd_q;
    logic              rd_valid;

    assign tick = (presc == PW'(DIV - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            presc <= '0;
        else
            presc <= tick ? '0 : presc + PW'(1);
    end

    // Address decode; channel windows are 4-byte aligned above the global block.
    assign offset  = BUS_ADDR - BASE_ADDR;
    assign hit     = (BUS_ADDR >= BASE_ADDR) && (offset < 8'(WIN));
    assign wr      = hit && BUS_WE;
    assign rd      = hit && !BUS_WE;
    assign is_glob = offset < 8'(CH_BASE);
    assign ch_off  = offset - 8'(CH_BASE);
    assign ch_idx  = ch_off[7:2];
    assign sub     = ch_off[1:0];
    assign wdata   = BUS_DATA;
    assign wbits   = wdata[NUM_CH-1:0];
    assign restart = (wr && offset == OFF_RESTART) ? wbits : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [CNT_W-1:0] count_w;
        logic [CNT_W-1:0] period_w;

        timer_channel #(
            .CNT_W       (CNT_W),
            .RESET_PERIOD((c == 0) ? 16'(DEFAULT_PERIOD) : 16'd0)
        ) u_ch (
            .clk    (CLK),
            .rst    (RESET),
            .tick   (tick),
            .en     (en_q[c]),
            .mode   (mode_e'(mode_q[c])),
            .restart(restart[c]),
            .wr_lo  (wr && !is_glob && ch_idx == 6'(c) && sub == SUB_PERIOD_LO),
            .wr_hi  (wr && !is_glob && ch_idx == 6'(c) && sub == SUB_PERIOD_HI),
            .wdata  (wdata),
            .count  (count_w),
            .period (period_w),
            .fire   (fire[c]),
            .disarm (disarm[c])
        );

        assign count_ext[c]  = 16'(count_w);
        assign period_ext[c] = 16'(period_w);
    end

    // Event set beats both a same-cycle W1C write and an ACK.
    always_comb begin
        en_next = en_q;
        if (wr && offset == OFF_EN)
            en_next = wbits;
        en_next = en_next & ~disarm;

        status_next = status_q;
        if (wr && offset == OFF_STATUS)
            status_next = status_next & ~wbits;
        if (BUS_INTERRUPT_ACK)
            status_next = status_next & ~imask_q;
        status_next = status_next | fire;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            en_q                <= NUM_CH'(1);
            mode_q              <= '0;
            status_q            <= '0;
            imask_q             <= NUM_CH'(1);
            BUS_INTERRUPT_RAISE <= 1'b0;
        end else begin
            en_q                <= en_next;
            status_q            <= status_next;
            BUS_INTERRUPT_RAISE <= |(status_q & imask_q);
            if (wr && offset == OFF_MODE)
                mode_q <= wbits;
            if (wr && offset == OFF_IMASK)
                imask_q <= wbits;
        end
    end

`ifdef TIMER_OVERRUN_EN
    logic [NUM_CH-1:0] ovr_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            ovr_q <= '0;
        else
            ovr_q <= (ovr_q & ~((wr && offset == OFF_OVERRUN) ? wbits : '0)) | (fire & status_q);
    end

    assign ovr_rd = ovr_q;
`else
    assign ovr_rd = '0;
`endif

    always_comb begin
        rd_mux = 8'h00;
        if (is_glob) begin
            case (offset)
                OFF_EN:      rd_mux = 8'(en_q);
                OFF_MODE:    rd_mux = 8'(mode_q);
                OFF_STATUS:  rd_mux = 8'(status_q);
                OFF_IMASK:   rd_mux = 8'(imask_q);
                OFF_OVERRUN: rd_mux = 8'(ovr_rd);
                default:     rd_mux = 8'h00;
            endcase
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_idx == 6'(c)) begin
                    case (sub)
                        SUB_PERIOD_LO: rd_mux = period_ext[c][7:0];
                        SUB_PERIOD_HI: rd_mux = period_ext[c][15:8];
                        SUB_COUNT_LO:  rd_mux = count_ext[c][7:0];
                        default:       rd_mux = shadow[c];
                    endcase
                end
            end
        end
    end

    // COUNT_LO read snapshots the high byte so a LO-then-HI pair is coherent.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < NUM_CH; c++)
                shadow[c] <= 8'h00;
            rd_q     <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd;
            if (rd)
                rd_q <= rd_mux;
            for (int c = 0; c < NUM_CH; c++)
                if (rd && !is_glob && ch_idx == 6'(c) && sub == SUB_COUNT_LO)
                    shadow[c] <= count_ext[c][15:8];
        end
    end

    assign BUS_DATA = (rd_valid && !BUS_WE) ? rd_q : 8'hzz;

endmodule

// File: tb/tb_multi_channel_timer.sv
// tb/tb_multi_channel_timer.sv - self-checking bench for multi_channel_timer with a behavioural model
module tb_multi_channel_timer;

    localparam logic [7:0] BASE = 8'hE0;
    localparam int NCH  = 2;
    localparam int DIV  = 10;
    localparam int DEFP = 100;
    localparam int MASK = (1 << NCH) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       we = 1'b0;
    logic       ack = 1'b0;
    logic       drive = 1'b0;
    logic [7:0] addr = 8'h00;
    logic [7:0] tdata = 8'h00;
    wire  [7:0] bus_data;
    logic       irq;

    assign bus_data = drive ? tdata : 8'hzz;
    always #5 clk = ~clk;

    multi_channel_timer #(
        .BASE_ADDR(BASE), .NUM_CH(NCH), .CNT_W(16),
        .CLK_HZ(1000), .TICK_HZ(100), .DEFAULT_PERIOD(DEFP)
    ) dut (
        .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .BUS_ADDR(addr),
        .BUS_WE(we), .BUS_INTERRUPT_RAISE(irq), .BUS_INTERRUPT_ACK(ack)
    );

    int checks = 0;
    int failures = 0;

    int m_phase, m_en, m_mode, m_status, m_imask, m_ovr, m_irq;
    int m_cnt[NCH];
    int m_per[NCH];
    int m_shadow[NCH];
    bit m_rd_pend;
    int m_rd_exp;
    logic [7:0] last_rd;

    typedef struct {
        bit         w;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_en = 1; m_mode = 0; m_status = 0; m_imask = 1; m_ovr = 0; m_irq = 0;
        for (int c = 0; c < NCH; c++) begin
            m_cnt[c] = 0;
            m_per[c] = (c == 0) ? DEFP : 0;
            m_shadow[c] = 0;
        end
        m_rd_pend = 0;
    endtask

    task automatic model_read(input int off, output int v);
        int ch, sb;
        v = 0;
        if (off < 8) begin
            case (off)
                0: v = m_en;
                1: v = m_mode;
                3: v = m_status;
                4: v = m_imask;
`ifdef TIMER_OVERRUN_EN
                5: v = m_ovr;
`endif
                default: v = 0;
            endcase
        end else begin
            ch = (off - 8) / 4;
            sb = (off - 8) % 4;
            case (sb)
                0: v = m_per[ch] % 256;
                1: v = m_per[ch] / 256;
                2: begin v = m_cnt[ch] % 256; m_shadow[ch] = m_cnt[ch] / 256; end
                default: v = m_shadow[ch];
            endcase
        end
    endtask

    // Time advances in whole ticks every DIV cycles; each channel counts ticks modulo its period.
    task automatic model_step(input bit w, input logic [7:0] a, input logic [7:0] d, input bit k);
        int off, fired, rs, w1c, w1c_ovr, st_old, im_old, mode_old;
        bit hit, tick;
        off = int'(a) - int'(BASE);
        hit = (off >= 0) && (off < 8 + 4 * NCH);
        tick = (m_phase == DIV - 1);
        fired = 0; rs = 0; w1c = 0; w1c_ovr = 0;
        st_old = m_status; im_old = m_imask; mode_old = m_mode;
        m_rd_pend = 0;
        if (hit && !w) begin
            m_rd_pend = 1;
            model_read(off, m_rd_exp);
        end
        if (hit && w && off == 2) rs = int'(d) & MASK;
        for (int c = 0; c < NCH; c++) begin
            if (rs[c]) m_cnt[c] = 0;
            else if (m_en[c] && m_per[c] != 0 && tick) begin
                if (m_cnt[c] == m_per[c] - 1) begin
                    m_cnt[c] = 0;
                    fired |= (1 << c);
                end else begin
                    m_cnt[c] = (m_cnt[c] + 1) % 65536;
                end
            end
        end
        m_phase = (m_phase + 1) % DIV;
        if (hit && w) begin
            if (off == 0) m_en = int'(d) & MASK;
            else if (off == 1) m_mode = int'(d) & MASK;
            else if (off == 3) w1c = int'(d);
            else if (off == 4) m_imask = int'(d) & MASK;
            else if (off == 5) w1c_ovr = int'(d);
            else if (off >= 8) begin
                if ((off - 8) % 4 == 0) m_per[(off - 8) / 4] = (m_per[(off - 8) / 4] / 256) * 256 + int'(d);
                if ((off - 8) % 4 == 1) m_per[(off - 8) / 4] = m_per[(off - 8) / 4] % 256 + int'(d) * 256;
            end
        end
        m_en = m_en & ~(fired & mode_old) & MASK;
        m_status = ((st_old & ~w1c & ~(k ? im_old : 0)) | fired) & MASK;
`ifdef TIMER_OVERRUN_EN
        m_ovr = ((m_ovr & ~w1c_ovr) | (fired & st_old)) & MASK;
`endif
        m_irq = ((st_old & im_old) != 0) ? 1 : 0;
    endtask

    task automatic cycle(input bit w, input logic [7:0] a, input logic [7:0] d, input bit k);
        we = w; addr = a; tdata = d; drive = w; ack = k;
        model_step(w, a, d, k);
        @(posedge clk);
        @(negedge clk);
        check("irq", int'(irq), m_irq);
        if (m_rd_pend) begin
            last_rd = bus_data;
            check($sformatf("rd@%02h", a), int'(bus_data), m_rd_exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        cycle(1'b1, a, d, 1'b0);
    endtask

    task automatic rd_reg(input logic [7:0] a, output logic [7:0] v);
        cycle(1'b0, a, 8'h00, 1'b0);
        v = last_rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b1; we = 1'b0; drive = 1'b0; ack = 1'b0; addr = 8'h00;
        #1 check("rst_irq", int'(irq), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    vec_t tbl[$];
    logic [7:0] v;

    initial begin
        model_reset();
        do_reset();

        tbl = '{
            '{1'b0, 8'hE0, 8'h00, 8'h01}, '{1'b0, 8'hE1, 8'h00, 8'h00},
            '{1'b0, 8'hE2, 8'h00, 8'h00}, '{1'b0, 8'hE3, 8'h00, 8'h00},
            '{1'b0, 8'hE4, 8'h00, 8'h01}, '{1'b0, 8'hE5, 8'h00, 8'h00},
            '{1'b0, 8'hE6, 8'h00, 8'h00}, '{1'b0, 8'hE7, 8'h00, 8'h00},
            '{1'b0, 8'hE8, 8'h00, 8'h64}, '{1'b0, 8'hE9, 8'h00, 8'h00},
            '{1'b0, 8'hEC, 8'h00, 8'h00}, '{1'b0, 8'hED, 8'h00, 8'h00},
            '{1'b1, 8'hE1, 8'hFF, 8'h00}, '{1'b0, 8'hE1, 8'h00, 8'h03},
            '{1'b1, 8'hE4, 8'hFE, 8'h00}, '{1'b0, 8'hE4, 8'h00, 8'h02},
            '{1'b1, 8'hEC, 8'hA5, 8'h00}, '{1'b1, 8'hED, 8'h5A, 8'h00},
            '{1'b0, 8'hEC, 8'h00, 8'hA5}, '{1'b0, 8'hED, 8'h00, 8'h5A},
            '{1'b1, 8'hE6, 8'hFF, 8'h00}, '{1'b0, 8'hE6, 8'h00, 8'h00},
            '{1'b1, 8'hE5, 8'hFF, 8'h00}, '{1'b0, 8'hE5, 8'h00, 8'h00},
            '{1'b1, 8'hE0, 8'h00, 8'h00}, '{1'b0, 8'hE0, 8'h00, 8'h00}
        };
        foreach (tbl[i]) begin
            if (tbl[i].w) wr_reg(tbl[i].a, tbl[i].d);
            else begin
                rd_reg(tbl[i].a, v);
                check($sformatf("tbl[%0d]", i), int'(v), int'(tbl[i].exp));
            end
        end

        // Default channel 0: event on tick 100 (edge 999), raise one edge later.
        do_reset();
        idle(1000);
        check("ch0_irq_early", int'(irq), 0);
        idle(1);
        check("ch0_irq", int'(irq), 1);
        rd_reg(8'hE3, v);
        check("ch0_status", int'(v), 8'h01);
        cycle(1'b0, 8'h00, 8'h00, 1'b1);
        rd_reg(8'hE3, v);
        check("ack_status", int'(v), 8'h00);
        check("ack_irq", int'(irq), 0);
        idle(1000);
        check("ch0_irq_again", int'(irq), 1);
        do_reset();

        // One-shot on channel 1.
        wr_reg(8'hEC, 8'h03);
        wr_reg(8'hED, 8'h00);
        wr_reg(8'hE1, 8'h02);
        wr_reg(8'hE0, 8'h03);
        idle(40);
        rd_reg(8'hE0, v);
        check("oneshot_en", int'(v), 8'h01);
        rd_reg(8'hE3, v);
        check("oneshot_st", int'(v) & 2, 2);
        wr_reg(8'hE3, 8'h02);
        idle(100);
        rd_reg(8'hE3, v);
        check("oneshot_once", int'(v) & 2, 0);

        // Masked periodic channel 1, period 258 ticks.
        do_reset();
        wr_reg(8'hE0, 8'h02);
        wr_reg(8'hE4, 8'h00);
        wr_reg(8'hEC, 8'h02);
        wr_reg(8'hED, 8'h01);
        idle(2600);
        rd_reg(8'hE3, v);
        check("masked_st", int'(v) & 2, 2);
        check("masked_irq", int'(irq), 0);
        wr_reg(8'hE3, 8'h02);
        rd_reg(8'hE3, v);
        check("masked_w1c", int'(v) & 2, 0);

        // Counter readback after exactly 300 ticks.
        do_reset();
        wr_reg(8'hEC, 8'h00);
        wr_reg(8'hED, 8'h02);
        wr_reg(8'hE0, 8'h02);
        idle(3002);
        rd_reg(8'hEE, v);
        check("cnt_lo", int'(v), 8'h2C);
        rd_reg(8'hEF, v);
        check("cnt_hi", int'(v), 8'h01);

        // Restart on the tick that would fire channel 0.
        do_reset();
        idle(999);
        wr_reg(8'hE2, 8'h01);
        rd_reg(8'hEA, v);
        check("restart_cnt", int'(v), 0);
        rd_reg(8'hE3, v);
        check("restart_noev", int'(v), 0);
        idle(20);
        rd_reg(8'hEA, v);
        check("restart_resume", int'(v), 2);

        // Overrun on channel 1 with period 2.
        do_reset();
        wr_reg(8'hEC, 8'h02);
        wr_reg(8'hE0, 8'h02);
        idle(45);
        rd_reg(8'hE5, v);
`ifdef TIMER_OVERRUN_EN
        check("overrun", int'(v), 8'h02);
`else
        check("overrun", int'(v), 8'h00);
`endif

        // Randomised traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int sel;
            logic [7:0] a, d;
            sel = $urandom_range(0, 9);
            a = 8'($urandom_range(8'hDC, 8'hF7));
            d = 8'($urandom_range(0, 255));
            if (a == 8'hE9 || a == 8'hED) d = 8'h00;
            if (a == 8'hE8 || a == 8'hEC) d = 8'($urandom_range(0, 6));
            if (sel < 4) idle(1);
            else if (sel < 7) cycle(1'b0, a, 8'h00, 1'b0);
            else if (sel < 9) cycle(1'b1, a, d, 1'b0);
            else cycle(1'b0, 8'h00, 8'h00, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
